// File: rtl/grf_wb_queue_pkg.sv
// Shared CPU constants used by the GRF write-back queue and its neighbours.
// Register zero is hard-wired, so writes to it are never queued or forwarded.
package grf_wb_queue_pkg;

    localparam int GRF_AW = 5;
    localparam int GRF_DW = 32;

    localparam logic [GRF_AW-1:0] GRF_REG_ZERO = 5'd0;

    // Entry word layout, shared with anything that packs queue entries: {pc, addr, data}.
    localparam int GRF_ENTRY_W = GRF_AW + 2 * GRF_DW;

endpackage

// File: rtl/grf_wb_queue_if.sv
// Producer-side request channel and GRF write port of the write-back queue.
// Handshake: a request transfers on a clock edge where in_valid && in_ready; in_valid holds until then.
interface grf_wb_queue_if #(
    parameter int AW = 5,
    parameter int DW = 32
);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_pc;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;

    logic          drain_en;
    logic          grf_we;
    logic [AW-1:0] grf_a3;
    logic [DW-1:0] grf_wd;
    logic [DW-1:0] grf_pc;

    modport master (
        output in_valid, in_pc, in_addr, in_data, drain_en,
        input  in_ready, grf_we, grf_a3, grf_wd, grf_pc
    );

    modport slave (
        input  in_valid, in_pc, in_addr, in_data, drain_en,
        output in_ready, grf_we, grf_a3, grf_wd, grf_pc
    );

endinterface

// File: rtl/grf_wbq_match.sv
// Forwarding lookup over the queued entries: finds the youngest valid entry
// whose destination equals rd_addr_i (register zero never hits).
module grf_wbq_match
    import grf_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = GRF_AW,
    parameter int DW    = GRF_DW
) (
    input  logic [DEPTH-1:0][AW-1:0]   addr_vec_i,
    input  logic [DEPTH-1:0][DW-1:0]   data_vec_i,
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    input  logic [$clog2(DEPTH):0]     count_i,
    input  logic [AW-1:0]              rd_addr_i,
    output logic                       hit_o,
    output logic [DW-1:0]              data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] idx;

    // Walk oldest to youngest; a later match overrides, so the youngest wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PW'(k);
            if ((CW'(k) < count_i) && (addr_vec_i[idx] == rd_addr_i) &&
                (rd_addr_i != AW'(GRF_REG_ZERO))) begin
                hit_o  = 1'b1;
                data_o = data_vec_i[idx];
            end
        end
    end

endmodule

// File: rtl/grf_wb_queue.sv
// Write-back queue in front of the single GRF write port: buffers register writes,
// drains one per cycle when the port is free, and forwards still-queued values to readers.
module grf_wb_queue
    import grf_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = GRF_AW,
    parameter int DW    = GRF_DW
) (
    input  logic                       clk,
    input  logic                       reset,
    grf_wb_queue_if.slave              wbq,
    input  logic [AW-1:0]              rd_a1_i,
    input  logic [AW-1:0]              rd_a2_i,
    output logic                       hit1_o,
    output logic                       hit2_o,
    output logic [DW-1:0]              fwd1_o,
    output logic [DW-1:0]              fwd2_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     dbg_count_o,
    output logic [$clog2(DEPTH)-1:0]   dbg_head_o,
    output logic [$clog2(DEPTH)-1:0]   dbg_tail_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Entry storage is deliberately not reset; count alone defines validity.
    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [DEPTH-1:0][DW-1:0] pc_q;

    logic full, empty;
    logic accept, store, drain;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Writes to register zero are consumed but never stored.
    assign accept = wbq.in_valid && !full && !reset;
    assign store  = accept && (wbq.in_addr != AW'(GRF_REG_ZERO));
    assign drain  = !empty && wbq.drain_en && !reset;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (store) begin
            tail_d = tail_q + PW'(1);
        end
        if (drain) begin
            head_d = head_q + PW'(1);
        end
        case ({store, drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            addr_q[tail_q] <= wbq.in_addr;
            data_q[tail_q] <= wbq.in_data;
            pc_q[tail_q]   <= wbq.in_pc;
        end
    end

    // No pass-through: in_ready depends on occupancy only.
    assign wbq.in_ready = !full;
    assign wbq.grf_we   = drain;
    assign wbq.grf_a3   = addr_q[head_q];
    assign wbq.grf_wd   = data_q[head_q];
    assign wbq.grf_pc   = pc_q[head_q];

    grf_wbq_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match1 (
        .addr_vec_i (addr_q),
        .data_vec_i (data_q),
        .head_i     (head_q),
        .count_i    (count_q),
        .rd_addr_i  (rd_a1_i),
        .hit_o      (hit1_o),
        .data_o     (fwd1_o)
    );

    grf_wbq_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match2 (
        .addr_vec_i (addr_q),
        .data_vec_i (data_q),
        .head_i     (head_q),
        .count_i    (count_q),
        .rd_addr_i  (rd_a2_i),
        .hit_o      (hit2_o),
        .data_o     (fwd2_o)
    );

    assign full_o      = full;
    assign empty_o     = empty;
    assign dbg_count_o = count_q;
    assign dbg_head_o  = head_q;
    assign dbg_tail_o  = tail_q;

endmodule

// File: tb/tb_grf_wb_queue.sv
// Bench for grf_wb_queue: a vector table plus directed and random sequences,
// checked against a reference queue of pending {pc, addr, data} entries.
module tb_grf_wb_queue;
  import grf_wb_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW = GRF_AW;
  localparam int DW = GRF_DW;
  localparam int W = AW + 2 * DW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_wb_queue_if #(.AW(AW), .DW(DW)) bus ();

  logic [AW-1:0] rd_a1, rd_a2;
  logic          hit1, hit2;
  logic [DW-1:0] fwd1, fwd2;
  logic          full, empty;
  logic [2:0]    dbg_count;
  logic [1:0]    dbg_head, dbg_tail;

  grf_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .wbq         (bus.slave),
    .rd_a1_i     (rd_a1),
    .rd_a2_i     (rd_a2),
    .hit1_o      (hit1),
    .hit2_o      (hit2),
    .fwd1_o      (fwd1),
    .fwd2_o      (fwd2),
    .full_o      (full),
    .empty_o     (empty),
    .dbg_count_o (dbg_count),
    .dbg_head_o  (dbg_head),
    .dbg_tail_o  (dbg_tail)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int mh = 0;
  int mt = 0;

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] pc;
    logic          dr;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    int            cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic void lookup(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    if (a != '0) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i][AW+DW-1:DW] == a) begin
          h = 1'b1;
          d = exp_q[i][DW-1:0];
          break;
        end
      end
    end
  endfunction

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] pc, input logic dr,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.in_pc    = pc;
    bus.drain_en = dr;
    rd_a1 = r1;
    rd_a2 = r2;
  endtask

  // One clock: check combinational outputs mid-cycle, update the model, check state after the edge.
  task automatic step();
    logic          exp_rdy, exp_we, h;
    logic [DW-1:0] d;
    logic [W-1:0]  e;
    @(negedge clk);
    exp_rdy = (exp_q.size() != DEPTH);
    exp_we  = (exp_q.size() != 0) && bus.drain_en;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("full", 64'(full), 64'(exp_q.size() == DEPTH));
    chk("empty", 64'(empty), 64'(exp_q.size() == 0));
    chk("grf_we", 64'(bus.grf_we), 64'(exp_we));
    lookup(rd_a1, h, d);
    chk("hit1", 64'(hit1), 64'(h));
    chk("fwd1", 64'(fwd1), 64'(d));
    lookup(rd_a2, h, d);
    chk("hit2", 64'(hit2), 64'(h));
    chk("fwd2", 64'(fwd2), 64'(d));
    if (exp_we) begin
      e = exp_q.pop_front();
      chk("grf_a3", 64'(bus.grf_a3), 64'(e[AW+DW-1:DW]));
      chk("grf_wd", 64'(bus.grf_wd), 64'(e[DW-1:0]));
      chk("grf_pc", 64'(bus.grf_pc), 64'(e[W-1:AW+DW]));
      mh = (mh + 1) % DEPTH;
    end
    if (bus.in_valid && exp_rdy && bus.in_addr != '0) begin
      exp_q.push_back({bus.in_pc, bus.in_addr, bus.in_data});
      mt = (mt + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
    chk("count", 64'(dbg_count), 64'(exp_q.size()));
    chk("head", 64'(dbg_head), 64'(mh));
    chk("tail", 64'(dbg_tail), 64'(mt));
  endtask

  // Reset with a live request and drain_en high: neither may take effect.
  task automatic do_reset();
    reset = 1'b1;
    drive(1'b1, 5'd3, 32'hDEAD, 32'h100, 1'b1, 5'd3, 5'd0);
    @(negedge clk);
    chk("rst_grf_we", 64'(bus.grf_we), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
    exp_q.delete();
    mh = 0;
    mt = 0;
    chk("rst_count", 64'(dbg_count), 64'(0));
    chk("rst_head", 64'(dbg_head), 64'(0));
    chk("rst_tail", 64'(dbg_tail), 64'(0));
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    do_reset();

    //          v  a   data       pc        dr r1  r2 cnt-after
    tbl.push_back('{1'b1, 5'd5,  32'h1234, 32'h3000, 1'b1, 5'd5, 5'd0, 1});
    tbl.push_back('{1'b0, 5'd0,  32'h0,    32'h0,    1'b1, 5'd5, 5'd0, 0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,    32'h0,    1'b1, 5'd5, 5'd0, 0});
    tbl.push_back('{1'b1, 5'd1,  32'h11,   32'h4000, 1'b0, 5'd1, 5'd2, 1});
    tbl.push_back('{1'b1, 5'd2,  32'h22,   32'h4004, 1'b0, 5'd1, 5'd2, 2});
    tbl.push_back('{1'b1, 5'd3,  32'h33,   32'h4008, 1'b0, 5'd3, 5'd2, 3});
    tbl.push_back('{1'b1, 5'd4,  32'h44,   32'h400C, 1'b0, 5'd4, 5'd1, 4});
    tbl.push_back('{1'b1, 5'd9,  32'h99,   32'h4010, 1'b0, 5'd9, 5'd4, 4});
    tbl.push_back('{1'b1, 5'd9,  32'h99,   32'h4010, 1'b1, 5'd1, 5'd9, 3});
    tbl.push_back('{1'b1, 5'd10, 32'hAA,   32'h4014, 1'b1, 5'd2, 5'd10, 3});
    tbl.push_back('{1'b0, 5'd0,  32'h0,    32'h0,    1'b1, 5'd3, 5'd10, 2});
    tbl.push_back('{1'b0, 5'd0,  32'h0,    32'h0,    1'b1, 5'd4, 5'd10, 1});
    tbl.push_back('{1'b0, 5'd0,  32'h0,    32'h0,    1'b1, 5'd10, 5'd4, 0});
    tbl.push_back('{1'b1, 5'd0,  32'hFFFF, 32'h5000, 1'b1, 5'd0, 5'd0, 0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,    32'h0,    1'b1, 5'd0, 5'd0, 0});
    tbl.push_back('{1'b1, 5'd7,  32'hA,    32'h6000, 1'b0, 5'd7, 5'd0, 1});
    tbl.push_back('{1'b1, 5'd7,  32'hB,    32'h6004, 1'b0, 5'd7, 5'd0, 2});
    tbl.push_back('{1'b0, 5'd0,  32'h0,    32'h0,    1'b0, 5'd7, 5'd7, 2});
    tbl.push_back('{1'b0, 5'd0,  32'h0,    32'h0,    1'b1, 5'd7, 5'd0, 1});
    tbl.push_back('{1'b0, 5'd0,  32'h0,    32'h0,    1'b1, 5'd7, 5'd0, 0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,    32'h0,    1'b0, 5'd7, 5'd0, 0});

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].pc, tbl[i].dr, tbl[i].r1, tbl[i].r2);
      step();
      chk($sformatf("tbl_cnt[%0d]", i), 64'(dbg_count), 64'(tbl[i].cnt));
    end

    // Fill, then hold in_valid and drain_en high across 3*DEPTH cycles to wrap the pointers.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 5'(i + 11), 32'(i + 32'h700), 32'(32'h8000 + 4 * i), 1'b0, 5'd12, 5'd0);
      step();
    end
    for (int i = 0; i < 3 * DEPTH; i++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 32'(32'h9000 + 4 * i), 1'b1,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      step();
      chk("wrap_cnt", 64'(dbg_count), 64'(DEPTH - 1));
    end

    // Random traffic with a narrow address range so forwarding hits are frequent.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 6)), $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)));
      step();
    end

    // Reset mid-operation with three entries queued.
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 5'd0);
    while (exp_q.size() != 0) step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(i + 20), 32'(i + 32'hC0), 32'(32'hA000 + 4 * i), 1'b0, 5'd20, 5'd21);
      step();
    end
    chk("pre_rst_cnt", 64'(dbg_count), 64'(3));
    do_reset();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd20, 5'd21);
    step();
    drive(1'b1, 5'd6, 32'h66, 32'hB000, 1'b1, 5'd6, 5'd20);
    step();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd6, 5'd20);
    step();
    step();

    chk("final_empty", 64'(empty), 64'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grf_wb_queue.md
# grf_wb_queue

Write-back queue feeding the GRF write port of the pipelined CPU. Buffers register-write requests (PC, destination, data) from the write-back stage and multi-cycle producers, then drains at most one per cycle into the register file's single write port. Provides a two-address forwarding lookup so readers see values still queued and not yet committed to the GRF.

## Interface
- DEPTH, 4, number of queued entries; power of two, ≥2
- AW, 5, register address width
- DW, 32, data and PC width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  producer has a write request
- in_ready  out  1  queue can accept a request this cycle
- in_pc  in  DW  PC of the producing instruction
- in_addr  in  AW  destination register
- in_data  in  DW  value to write
- drain_en  in  1  GRF write port is available this cycle
- grf_we  out  1  GRF write enable
- grf_a3  out  AW  GRF write address
- grf_wd  out  DW  GRF write data
- grf_pc  out  DW  PC forwarded to the GRF for its write log
- rd_a1, rd_a2  in  AW  reader addresses for forwarding lookup
- hit1, hit2  out  1  queued write pending for rd_a1 / rd_a2
- fwd1, fwd2  out  DW  data of the newest pending write to that address
- full, empty  out  1  occupancy flags

## Operation
- Circular buffer of DEPTH entries {pc, addr, data}; head pointer, tail pointer, count register (width clog2(DEPTH)+1). Pointers wrap modulo DEPTH.
- in_ready = !full. A handshake occurs when in_valid && in_ready.
- Handshake with in_addr != 0: entry written at tail, tail advances.
- Handshake with in_addr == 0: request is consumed and discarded; no entry is written; pointers and count are unchanged.
- Drain: grf_we = !empty && drain_en. grf_a3, grf_wd and grf_pc always show the head entry. On a cycle with grf_we high, head advances at the clock edge.
- Count update: +1 on a stored enqueue, −1 on a drain, unchanged when both or neither occur.
- Full: in_ready stays low even if a drain happens the same cycle; there is no pass-through.
- Empty: grf_we is 0, and the grf_* data outputs are don't-care but stable.
- Lookup: hitN is high when any valid entry has addr == rd_aN and rd_aN != 0. fwdN returns the data of the youngest matching entry, searching from tail−1 back to head. The head entry being drained this cycle counts as valid. Same-cycle incoming requests are not visible. On a miss, fwdN = 0.
- full = (count == DEPTH); empty = (count == 0).

## Timing
- All outputs are combinational from registered state plus the current inputs (drain_en, rd_aN). There is no internal combinational path from in_* to any output other than in_ready, and in_ready depends only on count.
- Enqueue at edge N: the entry appears at head no earlier than the cycle after edge N. Minimum enqueue-to-GRF write is one cycle: the GRF latches on edge N+1 when drain_en is high.
- An entry is visible to the lookup from the cycle after its enqueue edge up to and including its drain cycle. In that drain cycle the GRF still holds the old value, so forwarding covers the gap.
- Reset state: count=0, head=tail=0, full=0, empty=1, in_ready=1, grf_we=0, hit1=hit2=0, fwd1=fwd2=0. Buffer contents are not cleared.
- Reset during operation discards all queued entries. Requests presented in the reset cycle are not accepted, and nothing is drained in that cycle.

## Structure
- Shared CPU package or header: AW, DW, the register-zero constant 5'd0.
- The forwarding search is naturally a sub-module, grf_wbq_match. It takes the entry vectors, head and count plus one address, returns hit and data, and is instantiated twice. Everything else stays in the top module.

## Test plan
- Reset, then enqueue (pc=0x3000, addr=5, data=0x1234) with drain_en=1. Required: next cycle grf_we=1, grf_a3=5, grf_wd=0x1234, grf_pc=0x3000; the cycle after, empty=1.
- drain_en=0; enqueue addrs 1..4 with data 0x11..0x44. Required: full=1, in_ready=0, a fifth request is not accepted. Then set drain_en=1. Required: drain order 1,2,3,4; in_ready rises the cycle after the first drain.
- Enqueue addr=0, data=0xFFFF. Required: empty stays 1, grf_we never asserts, a lookup of rd_a1=0 gives hit1=0.
- drain_en=0; enqueue (7,0xA), (7,0xB). Required: with rd_a1=7, hit1=1 and fwd1=0xB. Then drain one entry. Required: still fwd1=0xB; after the second drain, hit1=0.
- Full queue with in_valid=1 and drain_en=1 on the same cycle. Required: no accept, one drain, count=DEPTH−1. Next cycle: simultaneous accept and drain leaves count unchanged; pointers wrap correctly over 3×DEPTH operations.
- With 3 entries queued, assert reset for one cycle. Required: empty=1, grf_we=0, hit1=hit2=0 immediately after; new enqueues behave as after a cold reset.
